// File: rtl/ct_ciu_bmb_bar_sched_if.sv
// Bus bundle between the bmbif kid channels, the scheduler and the BMB broadcast path.
// Optional watchdog error output present when CT_CIU_BMB_SCHED_TIMEOUT_EN is defined.
interface ct_ciu_bmb_bar_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0]   ch_bar_req;
  logic [NUM_CH*9-1:0] ch_req_bus;
  logic [NUM_CH*3-1:0] ch_mid;
  logic [NUM_CH-1:0]   ch_bar_grant;
  logic                sched_bmb_vld;
  logic                bmb_sched_rdy;
  logic [8:0]          sched_bmb_req_bus;
  logic [2:0]          sched_bmb_mid;
  logic [CH_W-1:0]     sched_bmb_ch;
  logic                bmb_cmplt_vld;
  logic [CH_W-1:0]     bmb_cmplt_ch;
  logic                sync_req;
  logic                sync_ack;
  logic                sched_idle;
`ifdef CT_CIU_BMB_SCHED_TIMEOUT_EN
  logic                sched_timeout_err;

  modport master (
    input  ch_bar_req, ch_req_bus, ch_mid, bmb_sched_rdy,
           bmb_cmplt_vld, bmb_cmplt_ch, sync_req,
    output ch_bar_grant, sched_bmb_vld, sched_bmb_req_bus, sched_bmb_mid,
           sched_bmb_ch, sync_ack, sched_idle, sched_timeout_err
  );
  modport slave (
    output ch_bar_req, ch_req_bus, ch_mid, bmb_sched_rdy,
           bmb_cmplt_vld, bmb_cmplt_ch, sync_req,
    input  ch_bar_grant, sched_bmb_vld, sched_bmb_req_bus, sched_bmb_mid,
           sched_bmb_ch, sync_ack, sched_idle, sched_timeout_err
  );
`else
  modport master (
    input  ch_bar_req, ch_req_bus, ch_mid, bmb_sched_rdy,
           bmb_cmplt_vld, bmb_cmplt_ch, sync_req,
    output ch_bar_grant, sched_bmb_vld, sched_bmb_req_bus, sched_bmb_mid,
           sched_bmb_ch, sync_ack, sched_idle
  );
  modport slave (
    output ch_bar_req, ch_req_bus, ch_mid, bmb_sched_rdy,
           bmb_cmplt_vld, bmb_cmplt_ch, sync_req,
    input  ch_bar_grant, sched_bmb_vld, sched_bmb_req_bus, sched_bmb_mid,
           sched_bmb_ch, sync_ack, sched_idle
  );
`endif
endinterface

// File: rtl/ct_ciu_bmb_bar_sched.sv
// Round-robin, credit-gated barrier scheduler onto the shared BMB issue path, with drain/sync.
// Define CT_CIU_BMB_SCHED_TIMEOUT_EN to add the sticky SEND-stall watchdog (sched_timeout_err).
module ct_ciu_bmb_bar_sched #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter int MAX_OUTST = 3,
  parameter int CNT_W     = 2
) (
  input logic                    forever_cpuclk,
  input logic                    cpurst,
  ct_ciu_bmb_bar_sched_if.master bif
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [NUM_CH];
  logic [CH_W-1:0]  r_rr_ptr;
  logic [CH_W-1:0]  r_ch;
  logic [8:0]       r_bus;
  logic [2:0]       r_mid;
  logic             r_vld;
  logic             r_sync_ack;

  logic [NUM_CH-1:0] w_elig;
  logic [NUM_CH-1:0] w_inc;
  logic [NUM_CH-1:0] w_dec;
  logic [CH_W-1:0]   w_win;
  logic              w_any_elig;
  logic              w_all_zero;
  logic              w_hs;

  assign w_hs = r_vld & bif.bmb_sched_rdy;

  always_comb begin
    w_all_zero = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      w_elig[i] = bif.ch_bar_req[i] & (r_cnt[i] < CNT_W'(MAX_OUTST));
      w_inc[i]  = w_hs & (r_ch == CH_W'(i));
      // Completions to an idle counter are dropped so the counter never wraps below zero.
      w_dec[i]  = bif.bmb_cmplt_vld & (bif.bmb_cmplt_ch == CH_W'(i)) & (r_cnt[i] != '0);
      if (r_cnt[i] != '0) w_all_zero = 1'b0;
    end
  end

  // Scan downward so the lowest offset from the round-robin pointer is the one left standing.
  always_comb begin
    w_win      = '0;
    w_any_elig = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_elig[CH_W'((int'(r_rr_ptr) + k) % NUM_CH)]) begin
        w_win      = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
        w_any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_ch       <= '0;
      r_bus      <= '0;
      r_mid      <= '0;
      r_vld      <= 1'b0;
      r_sync_ack <= 1'b0;
    end else begin
      r_sync_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bif.sync_req) begin
            r_state <= S_DRAIN;
          end else if (w_any_elig) begin
            r_ch    <= w_win;
            r_bus   <= bif.ch_req_bus[int'(w_win)*9 +: 9];
            r_mid   <= bif.ch_mid[int'(w_win)*3 +: 3];
            r_vld   <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (bif.bmb_sched_rdy) begin
            r_vld    <= 1'b0;
            r_rr_ptr <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
            r_state  <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (!bif.sync_req) begin
            r_state <= S_IDLE;
          end else if (w_all_zero) begin
            r_sync_ack <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bif.ch_bar_grant      = w_inc;
  assign bif.sched_bmb_vld     = r_vld;
  assign bif.sched_bmb_req_bus = r_bus;
  assign bif.sched_bmb_mid     = r_mid;
  assign bif.sched_bmb_ch      = r_ch;
  assign bif.sync_ack          = r_sync_ack;
  assign bif.sched_idle        = (r_state == S_IDLE) & w_all_zero;

`ifdef CT_CIU_BMB_SCHED_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_tmo_err;

  // Counts stalled SEND cycles, saturating; the error is sticky until reset.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_wdog    <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state == S_SEND && !bif.bmb_sched_rdy) begin
        if (r_wdog != 8'hFF) r_wdog <= r_wdog + 8'd1;
      end else begin
        r_wdog <= '0;
      end
      if (r_wdog == 8'hFF) r_tmo_err <= 1'b1;
    end
  end

  assign bif.sched_timeout_err = r_tmo_err;
`endif

endmodule

// File: tb/tb_ct_ciu_bmb_bar_sched.sv
// Testbench for ct_ciu_bmb_bar_sched: directed vector table, corner sequences, random vs model.
module tb_ct_ciu_bmb_bar_sched;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int MAXO   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ct_ciu_bmb_bar_sched_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bif ();

  ct_ciu_bmb_bar_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .MAX_OUTST(MAXO), .CNT_W(2)) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bif            (bif)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] pbus [NUM_CH];
  logic [2:0] pmid [NUM_CH];

  typedef struct {
    logic [3:0] req; logic rdy; logic cv; logic [1:0] cc; logic sync;
    logic vld; logic [3:0] gnt; logic [1:0] ch; logic idle; logic ack;
  } vec_t;
  vec_t tbl[$];

  assert property (@(posedge clk) disable iff (rst)
                   bif.sched_bmb_vld |-> bif.ch_bar_req[bif.sched_bmb_ch])
    else $error("FAIL req_drop: request of channel %0d dropped while in SEND", bif.sched_bmb_ch);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic rdy, input logic cv,
                       input logic [1:0] cc, input logic sync);
    bif.ch_bar_req    = req;
    bif.bmb_sched_rdy = rdy;
    bif.bmb_cmplt_vld = cv;
    bif.bmb_cmplt_ch  = cc;
    bif.sync_req      = sync;
    for (int i = 0; i < NUM_CH; i++) begin
      bif.ch_req_bus[i*9 +: 9] = pbus[i];
      bif.ch_mid[i*3 +: 3]     = pmid[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int oh2i(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  function automatic void add(input logic [3:0] rq, input logic rd, input logic cv, input logic [1:0] cc,
                              input logic sy, input logic ev, input logic [3:0] eg,
                              input logic [1:0] ech, input logic ei, input logic ea);
    vec_t v;
    v.req = rq; v.rdy = rd; v.cv = cv; v.cc = cc; v.sync = sy;
    v.vld = ev; v.gnt = eg; v.ch = ech; v.idle = ei; v.ack = ea;
    tbl.push_back(v);
  endfunction

  // Reference model state
  int         mcnt [NUM_CH];
  int         mrr, mch;
  bit         mfly, mdrain, mack;
  logic [8:0] mbus;
  logic [2:0] mmid;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      pbus[i] = 9'h1A0 + 9'(i);
      pmid[i] = 3'(i + 1);
    end
    do_reset();

    // ---------------- directed vector table ----------------
    //   req     rdy cv cc    sy  vld gnt     ch    idle ack
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);
    add(4'b0010, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);
    add(4'b0010, 1, 0, 2'd0, 0,  1, 4'b0010, 2'd1, 0, 0);
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 1, 1, 2'd1, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);
    add(4'b0010, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);
    add(4'b0010, 1, 0, 2'd0, 0,  1, 4'b0010, 2'd1, 0, 0);
    add(4'b0010, 0, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0010, 1, 1, 2'd1, 0,  1, 4'b0010, 2'd1, 0, 0);
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 1, 1, 2'd1, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);
    add(4'b0000, 1, 1, 2'd3, 0,  0, 4'b0000, 2'd0, 1, 0);
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);
    add(4'b0001, 0, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);
    for (int i = 0; i < 10; i++)
      add(4'b0001, 0, 0, 2'd0, 0, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  1, 4'b0001, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  1, 4'b0001, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  1, 4'b0001, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 1, 1, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    add(4'b0001, 1, 0, 2'd0, 0,  1, 4'b0001, 2'd0, 0, 0);
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(4'b0000, 1, 1, 2'd0, 0, 0, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 1, 0, 2'd0, 0,  0, 4'b0000, 2'd0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].rdy, tbl[i].cv, tbl[i].cc, tbl[i].sync);
      #1;
      chk($sformatf("v%0d.vld", i),  bif.sched_bmb_vld, tbl[i].vld);
      chk($sformatf("v%0d.gnt", i),  bif.ch_bar_grant,  tbl[i].gnt);
      chk($sformatf("v%0d.idle", i), bif.sched_idle,    tbl[i].idle);
      chk($sformatf("v%0d.ack", i),  bif.sync_ack,      tbl[i].ack);
      if (tbl[i].vld) begin
        chk($sformatf("v%0d.ch", i),  bif.sched_bmb_ch,      tbl[i].ch);
        chk($sformatf("v%0d.bus", i), bif.sched_bmb_req_bus, pbus[tbl[i].ch]);
        chk($sformatf("v%0d.mid", i), bif.sched_bmb_mid,     pmid[tbl[i].ch]);
      end
    end

    // ---------------- round-robin with immediate completions ----------------
    begin
      int ng, last, gch[5], gcyc[5];
      do_reset();
      ng = 0; last = -1;
      for (int c = 0; c < 40 && ng < 5; c++) begin
        @(negedge clk);
        drive(4'b1111, 1'b1, last >= 0, 2'(last < 0 ? 0 : last), 1'b0);
        #1;
        last = -1;
        if (bif.ch_bar_grant != 4'b0) begin
          chk("rr.onehot", $onehot(bif.ch_bar_grant), 1);
          gch[ng] = oh2i(bif.ch_bar_grant); gcyc[ng] = c; ng++;
          last = oh2i(bif.ch_bar_grant);
        end
      end
      chk("rr.count", ng, 5);
      for (int k = 0; k < ng; k++) begin
        chk($sformatf("rr.order%0d", k), gch[k], k % 4);
        if (k > 0) chk($sformatf("rr.space%0d", k), gcyc[k] - gcyc[k-1], 2);
      end
    end

    // ---------------- drain / sync ----------------
    begin
      int ng, acks, vld_pre, got0;
      do_reset();
      ng = 0;
      for (int c = 0; c < 20 && ng < 2; c++) begin
        @(negedge clk);
        drive(4'b0100, 1'b1, 1'b0, 2'd0, 1'b0);
        #1;
        if (bif.ch_bar_grant == 4'b0100) ng++;
      end
      chk("drain.setup_grants", ng, 2);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        drive(4'b0001, 1'b1, c >= 6, 2'd2, 1'b1);
        #1;
        chk($sformatf("drain.novld%0d", c), bif.sched_bmb_vld, 1'b0);
        chk($sformatf("drain.noack%0d", c), bif.sync_ack, 1'b0);
      end
      acks = 0; vld_pre = 0; got0 = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        drive(4'b0001, 1'b1, 1'b0, 2'd0, acks == 0);
        #1;
        if (bif.sync_ack) begin
          acks++;
          bif.sync_req = 1'b0;
        end
        if (bif.sched_bmb_vld && acks == 0) vld_pre++;
        if (bif.sched_bmb_vld && acks > 0 && bif.sched_bmb_ch == 2'd0) got0 = 1;
      end
      chk("drain.ack_count", acks, 1);
      chk("drain.vld_before_ack", vld_pre, 0);
      chk("drain.ch0_after", got0, 1);
    end

    // ---------------- reset while in SEND ----------------
    do_reset();
    @(negedge clk);
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("rst.pre_vld", bif.sched_bmb_vld, 1'b1);
    bif.bmb_sched_rdy = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst.vld", bif.sched_bmb_vld, 1'b0);
    chk("rst.gnt", bif.ch_bar_grant, 4'b0);
    chk("rst.ch", bif.sched_bmb_ch, 2'd0);
    @(negedge clk);
    drive(4'b0000, 1'b1, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.idle", bif.sched_idle, 1'b1);

`ifdef CT_CIU_BMB_SCHED_TIMEOUT_EN
    // ---------------- watchdog ----------------
    do_reset();
    chk("tmo.reset", bif.sched_timeout_err, 1'b0);
    for (int c = 0; c < 262; c++) begin
      @(negedge clk);
      drive(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
      #1;
      if (c == 200) chk("tmo.early", bif.sched_timeout_err, 1'b0);
    end
    chk("tmo.set", bif.sched_timeout_err, 1'b1);
    @(negedge clk);
    drive(4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("tmo.sticky", bif.sched_timeout_err, 1'b1);
`endif

    // ---------------- random against the reference model ----------------
    do_reset();
    for (int i = 0; i < NUM_CH; i++) mcnt[i] = 0;
    mrr = 0; mch = 0; mfly = 0; mdrain = 0; mack = 0; mbus = '0; mmid = '0;
    begin
      int sync_len, sum;
      int old [NUM_CH];
      logic [3:0] req;
      logic rdy, cv, sync;
      logic [1:0] cc;
      logic [3:0] eg;
      bit nack;
      sync_len = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
          if (mfly && i == mch) begin
            req[i] = 1'b1;
          end else begin
            req[i]  = ($urandom_range(0, 2) != 0);
            pbus[i] = 9'($urandom);
            pmid[i] = 3'($urandom);
          end
        end
        rdy = ($urandom_range(0, 3) != 0);
        cv  = ($urandom_range(0, 2) == 0);
        cc  = 2'($urandom);
        if (sync_len > 0) begin
          sync = 1'b1; sync_len--;
        end else begin
          sync = 1'b0;
          if ($urandom_range(0, 40) == 0) sync_len = $urandom_range(1, 12);
        end
        drive(req, rdy, cv, cc, sync);
        #1;

        sum = 0;
        for (int i = 0; i < NUM_CH; i++) begin old[i] = mcnt[i]; sum += mcnt[i]; end
        eg = (mfly && rdy) ? 4'(1 << mch) : 4'b0;
        chk("rnd.vld",  bif.sched_bmb_vld, mfly);
        chk("rnd.gnt",  bif.ch_bar_grant,  eg);
        chk("rnd.idle", bif.sched_idle,    !mfly && !mdrain && sum == 0);
        chk("rnd.ack",  bif.sync_ack,      mack);
        if (mfly) begin
          chk("rnd.ch",  bif.sched_bmb_ch,      mch);
          chk("rnd.bus", bif.sched_bmb_req_bus, mbus);
          chk("rnd.mid", bif.sched_bmb_mid,     mmid);
        end

        nack = mdrain && sync && sum == 0;
        if (cv && int'(cc) < NUM_CH && old[cc] > 0) mcnt[cc]--;
        if (mfly) begin
          if (rdy) begin
            mcnt[mch]++;
            mrr  = (mch + 1) % NUM_CH;
            mfly = 0;
          end
        end else if (mdrain) begin
          if (!sync || sum == 0) mdrain = 0;
        end else if (sync) begin
          mdrain = 1;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            int idx;
            idx = (mrr + k) % NUM_CH;
            if (req[idx] && old[idx] < MAXO) begin
              mfly = 1; mch = idx; mbus = pbus[idx]; mmid = pmid[idx];
              break;
            end
          end
        end
        mack = nack;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ct_ciu_bmb_bar_sched.md
Name: ct_ciu_bmb_bar_sched

Overview:
- Schedules barrier requests from NUM_CH bmbif kid channels onto the single shared BMB barrier issue path.
- Round-robin arbitration, gated by per-channel outstanding-credit limits.
- Registers the issued payload and tracks completions per channel.
- Provides a drain/sync handshake that blocks new issue until all outstanding barriers retire.
- Sits between the bmbif kid instances (bar_req/bar_grant) and the BMB broadcast logic in the CIU.

Parameters:
- NUM_CH, 4, number of requesting channels.
- CH_W, 2, channel id width; must satisfy 2^CH_W >= NUM_CH.
- MAX_OUTST, 3, maximum outstanding barriers per channel (1..2^CNT_W-1).
- CNT_W, 2, outstanding counter width.

Ports:
- forever_cpuclk  in  1  clock; single clock domain.
- cpurst  in  1  reset, asynchronous, active-high.
- ch_bar_req  in  NUM_CH  per-channel barrier request (level).
- ch_req_bus  in  NUM_CH*9  per-channel payload; channel i occupies [9i+8:9i].
- ch_mid  in  NUM_CH*3  per-channel master id.
- ch_bar_grant  out  NUM_CH  one-hot, one-cycle grant pulse (pop to kid).
- sched_bmb_vld  out  1  downstream request valid.
- bmb_sched_rdy  in  1  downstream ready.
- sched_bmb_req_bus  out  9  registered payload.
- sched_bmb_mid  out  3  registered master id.
- sched_bmb_ch  out  CH_W  registered channel id.
- bmb_cmplt_vld  in  1  completion strobe.
- bmb_cmplt_ch  in  CH_W  completing channel.
- sync_req  in  1  drain request (level).
- sync_ack  out  1  one-cycle drain-done pulse.
- sched_idle  out  1  no issue in flight and all counters zero.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, all counters=0. Outputs vld=0, grant=0, bus/mid/ch=0, sync_ack=0, sched_idle=1.
- Eligibility: eligible[i] = ch_bar_req[i] & (cnt[i] < MAX_OUTST).
- Winner: first eligible index scanning upward from rr_ptr with wrap-around.
- FSM IDLE:
  - If sync_req=1, go to DRAIN; no selection in that cycle. sync_req has priority over eligible requests.
  - Else if any channel is eligible, latch the winner's req_bus, mid and id into the output registers and go to SEND.
- FSM SEND:
  - sched_bmb_vld=1; payload is held stable until accepted.
  - On vld&rdy, in the same cycle: ch_bar_grant[winner]=1, cnt[winner]++, rr_ptr=winner+1 (mod NUM_CH), next state IDLE.
  - The vld&rdy cycle is the only cycle the grant is asserted.
  - Minimum issue spacing is 2 cycles; vld deasserts in the cycle after the handshake.
- FSM DRAIN:
  - No selection.
  - When all cnt==0 and sync_req=1: pulse sync_ack for 1 cycle and go to IDLE.
  - If sync_req drops before the drain completes: go to IDLE with no ack.
- Completion: on bmb_cmplt_vld, cnt[bmb_cmplt_ch]--.
  - Completion and issue on the same channel in the same cycle: counter unchanged.
  - Completion to a channel with cnt=0, or ch>=NUM_CH: ignored; counter saturates at 0.
- Requester contract:
  - A kid holds ch_bar_req and a stable payload from selection until its grant.
  - The scheduler does not re-sample the payload in SEND.
  - Dropping the request mid-SEND is illegal; the bench flags it as an assertion.
- sched_idle = (state==IDLE) & all cnt==0.
- Counter arithmetic is CNT_W bits with no wrap; the cnt<MAX_OUTST gate guarantees no overflow.

Optional Feature:
- Macro: CT_CIU_BMB_SCHED_TIMEOUT_EN.
- When defined:
  - Adds output sched_timeout_err (1 bit) and an 8-bit watchdog.
  - The watchdog counts cycles in SEND with rdy=0 and clears on handshake or on leaving SEND.
  - At count 255, sched_timeout_err is set sticky (cleared only by cpurst); FSM behaviour is unchanged.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single request: ch_bar_req=4'b0010, rdy=1 → vld rises 1 cycle later with sched_bmb_ch=1; grant[1] pulses in the handshake cycle; cnt[1]=1.
- Round-robin: all 4 requesting continuously, rdy=1, completions immediate → grant order 0,1,2,3,0 with one grant every 2 cycles.
- Credit limit: ch0 only, no completions → exactly 3 grants, then vld stays 0. One bmb_cmplt_vld with ch=0 → 4th grant issued.
- Backpressure: rdy=0 for 10 cycles in SEND → vld held, payload stable, no grant; rdy=1 → single grant. With macro defined and rdy=0 for 255 cycles → sched_timeout_err=1.
- Drain: 2 outstanding on ch2, sync_req=1 with ch0 requesting → no issue; after 2 completions, sync_ack pulses once, then ch0 is issued after sync_req drops.
- Simultaneous/reset: issue and completion on ch1 in the same cycle → cnt[1] unchanged. cpurst asserted in SEND → vld=0 immediately and sched_idle=1 after release.
